muldiv_sequencer: RTL

//  Multi-cycle HI/LO unit beside the EX-stage ALU: runs MULT/MULTU/DIV/DIVU by iterating

---
 rtl/muldiv_sequencer_if.sv | 24 ++
 rtl/muldiv_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if
//   Bundle between the EX stage and the HI/LO multiply/divide unit.
//   master : EX-stage side (drives the instruction, sees stall/result/HI/LO)
//   slave  : the muldiv unit
//   i_valid/i_func/i_rs/i_rt : instruction presented by EX this cycle
//   o_stall/o_busy/o_done    : pipeline freeze, unit occupied, HI/LO just written
//   o_result/o_hi/o_lo       : MFHI/MFLO read data and the architectural HI/LO
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  logic             i_valid;
  logic [5:0]       i_func;
  logic [WIDTH-1:0] i_rs;
  logic [WIDTH-1:0] i_rt;
  logic             o_stall;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;

  modport master (output i_valid, i_func, i_rs, i_rt,
                  input  o_stall, o_busy, o_done, o_result, o_hi, o_lo);
  modport slave  (input  i_valid, i_func, i_rs, i_rt,
                  output o_stall, o_busy, o_done, o_result, o_hi, o_lo);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle HI/LO unit next to the EX-stage ALU. Runs MULT/MULTU by
//   shift-add and DIV/DIVU by restoring division, one bit per cycle, and owns
//   HI/LO (MFHI/MFLO/MTHI/MTLO). Stalls the pipeline only when a HI/LO-class
//   instruction arrives while an operation is in flight.
// Ports
//   i_clk   : rising-edge clock
//   i_reset : synchronous active-high reset
//   bus     : muldiv_sequencer_if.slave (instruction in; stall/busy/done,
//             MF read data and HI/LO out)
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  muldiv_sequencer_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] hi, lo;
  // acc_hi/acc_lo: product upper/lower for MUL, remainder/quotient for DIV
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [WIDTH-1:0] opnd;          // multiplicand or divisor magnitude
  logic [CW-1:0]    cnt;
  logic             neg_res;       // product / quotient must be negated
  logic             neg_rem;       // remainder takes the dividend's sign
  logic             is_div;
  logic             div_zero;

  logic             accept, hilo_class, signed_op, rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_abs, rt_abs;
  logic [WIDTH:0]   msum, rsh, trial;
  logic [2*WIDTH-1:0] prod_neg;

  assign accept     = bus.i_valid && (bus.i_func inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
  assign hilo_class = bus.i_func inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                                         F_MULT, F_MULTU, F_DIV, F_DIVU};
  assign signed_op  = ~bus.i_func[0];
  assign rs_neg     = signed_op & bus.i_rs[WIDTH-1];
  assign rt_neg     = signed_op & bus.i_rt[WIDTH-1];
  assign rs_abs     = rs_neg ? -bus.i_rs : bus.i_rs;
  assign rt_abs     = rt_neg ? -bus.i_rt : bus.i_rt;

  // shift-add step: carry out of the upper half shifts into bit WIDTH-1
  assign msum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  // restoring step: shift {rem,quo} left, trial-subtract divisor
  assign rsh   = {acc_hi, acc_lo[WIDTH-1]};
  assign trial = rsh - {1'b0, opnd};
  assign prod_neg = -{acc_hi, acc_lo};

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (accept) state_nxt = bus.i_func[1] ? S_DIV : S_MUL;
      S_MUL, S_DIV: if (cnt == '0) state_nxt = S_FIX;
      S_FIX:        state_nxt = S_DONE;
      S_DONE:       state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hi       <= '0;
      lo       <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      cnt      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            is_div   <= bus.i_func[1];
            neg_res  <= rs_neg ^ rt_neg;
            neg_rem  <= rs_neg;
            div_zero <= (bus.i_rt == '0);
            cnt      <= CW'(WIDTH - 1);
            acc_hi   <= '0;
            if (bus.i_func[1]) begin
              acc_lo <= rs_abs;
              opnd   <= rt_abs;
            end else begin
              acc_lo <= rt_abs;
              opnd   <= rs_abs;
            end
          end else if (bus.i_valid && bus.i_func == F_MTHI) begin
            hi <= bus.i_rs;
          end else if (bus.i_valid && bus.i_func == F_MTLO) begin
            lo <= bus.i_rs;
          end
        end
        S_MUL: begin
          acc_hi <= msum[WIDTH:1];
          acc_lo <= {msum[0], acc_lo[WIDTH-1:1]};
          cnt    <= cnt - 1'b1;
        end
        S_DIV: begin
          if (!trial[WIDTH]) begin
            acc_hi <= trial[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi <= rsh[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - 1'b1;
        end
        S_FIX: begin
          if (!is_div) begin
            if (neg_res) {acc_hi, acc_lo} <= prod_neg;
          end else begin
            // divide by zero: quotient is all ones regardless of signs; the
            // sign-restored remainder is then exactly the original rs
            if (div_zero)     acc_lo <= '1;
            else if (neg_res) acc_lo <= -acc_lo;
            if (neg_rem)      acc_hi <= -acc_hi;
          end
        end
        S_DONE: begin
          hi <= acc_hi;
          lo <= acc_lo;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.o_result = '0;
    if (bus.i_valid && state == S_IDLE) begin
      if (bus.i_func == F_MFHI)      bus.o_result = hi;
      else if (bus.i_func == F_MFLO) bus.o_result = lo;
    end
  end

  assign bus.o_busy  = (state != S_IDLE);
  assign bus.o_done  = (state == S_DONE);
  assign bus.o_stall = bus.i_valid & bus.o_busy & hilo_class;
  assign bus.o_hi    = hi;
  assign bus.o_lo    = lo;
endmodule
